// File: rtl/fwd_pkg.sv
// fwd_pkg: shared encodings for the operand forwarding unit
package fwd_pkg;
  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC  = 2'b10;
  typedef enum logic [1:0] {FS_RF = 2'b00, FS_EX = 2'b01, FS_MEM = 2'b10, FS_WB = 2'b11} fwd_sel_e;
  typedef enum logic [1:0] {RUN, LU, HOLD} state_e;
endpackage

// File: rtl/fwd_src_slice.sv
// fwd_src_slice: per-source match, forwarding select and freeze hold latch
module fwd_src_slice
  import fwd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_hold,
  input  logic [REG_AW-1:0] addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_out,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [1:0]        mem_memtoreg,
  input  logic [DATA_W-1:0] mem_out,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [DATA_W-1:0] mem_pc_next,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] op,
  output logic [1:0]        sel,
  output logic              lu_hit
);
  logic              hit_ex, fwd_ex, hit_mem, hit_wb, live;
  logic [DATA_W-1:0] mem_val, live_val, hold_q;
  logic              hold_v;
  // match per level; a load in EX is not forwardable and falls through
  always_comb begin
    hit_ex   = ex_regwrite && ex_rd == addr && |addr;
    hit_mem  = mem_regwrite && mem_rd == addr && |addr;
    hit_wb   = wb_regwrite && wb_rd == addr && |addr;
    fwd_ex   = hit_ex && !ex_memread;
    lu_hit   = hit_ex && ex_memread;
    mem_val  = mem_memtoreg[1] ? mem_pc_next : mem_memtoreg == MTR_MEM ? mem_read_data : mem_out;
    live     = fwd_ex || hit_mem || hit_wb;
    live_val = fwd_ex ? ex_out : hit_mem ? mem_val : wb_data;
    sel      = fwd_ex ? FS_EX : hit_mem ? FS_MEM : hit_wb ? FS_WB : FS_RF;
    op       = live ? live_val : hold_v ? hold_q : rf_data;
  end
  // capture values retiring during a freeze; drop them once the front end moves
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold_q <= '0;
      hold_v <= 1'b0;
    end else if (id_hold) begin
      if (live) begin
        hold_q <= live_val;
        hold_v <= 1'b1;
      end
    end else hold_v <= 1'b0;
endmodule

// File: rtl/operand_forward_unit.sv
// operand_forward_unit: NUM_SRC-way EX/MEM/WB operand forwarding with load-use stall and freeze hold; FWD_PERF_CNT_EN adds perf counters
module operand_forward_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_hold,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic [NUM_SRC*DATA_W-1:0] src_rf_data,
  input  logic                      ex_regwrite,
  input  logic                      ex_memread,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic [DATA_W-1:0]         ex_out,
  input  logic                      mem_regwrite,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic [1:0]                mem_memtoreg,
  input  logic [DATA_W-1:0]         mem_out,
  input  logic [DATA_W-1:0]         mem_read_data,
  input  logic [DATA_W-1:0]         mem_pc_next,
  input  logic                      wb_regwrite,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic [DATA_W-1:0]         wb_data,
  output logic [NUM_SRC*DATA_W-1:0] op_out,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      lu_stall
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]               perf_lu_cnt,
  output logic [31:0]               perf_fwd_cnt
`endif
);
  logic [NUM_SRC-1:0] lu_hit;
  state_e             state, state_nx;
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    fwd_src_slice #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_slice (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_hold      (id_hold),
      .addr         (src_addr[g*REG_AW +: REG_AW]),
      .rf_data      (src_rf_data[g*DATA_W +: DATA_W]),
      .ex_regwrite  (ex_regwrite),
      .ex_memread   (ex_memread),
      .ex_rd        (ex_rd),
      .ex_out       (ex_out),
      .mem_regwrite (mem_regwrite),
      .mem_rd       (mem_rd),
      .mem_memtoreg (mem_memtoreg),
      .mem_out      (mem_out),
      .mem_read_data(mem_read_data),
      .mem_pc_next  (mem_pc_next),
      .wb_regwrite  (wb_regwrite),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .op           (op_out[g*DATA_W +: DATA_W]),
      .sel          (fwd_sel[g*2 +: 2]),
      .lu_hit       (lu_hit[g])
    );
  end
  // stall request and next state; a freeze owns the pipeline so it masks the stall
  always_comb begin
    lu_stall = |lu_hit && !id_hold;
    state_nx = id_hold ? HOLD : state == HOLD ? RUN : lu_stall ? LU : RUN;
  end
  // stall/freeze state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_nx;
`ifdef FWD_PERF_CNT_EN
  // saturating counters for load-use cycles and forwarded cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_lu_cnt  <= '0;
      perf_fwd_cnt <= '0;
    end else begin
      if (state == LU && ~&perf_lu_cnt) perf_lu_cnt <= perf_lu_cnt + 32'd1;
      if (|fwd_sel && ~&perf_fwd_cnt) perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
    end
`endif
  a_addr_stable_in_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (id_hold && $past(id_hold)) |-> $stable(src_addr));
endmodule

// File: tb/tb_operand_forward_unit.sv
// tb_operand_forward_unit: directed vector table plus stall/hold/reset sequences
module tb_operand_forward_unit;
  import fwd_pkg::*;
  localparam int DW = 32, AW = 5, NS = 2;
  logic           clk = 0, rst_n = 0, id_hold = 0;
  logic [NS*AW-1:0] src_addr;
  logic [NS*DW-1:0] src_rf_data, op_out;
  logic           ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, lu_stall;
  logic [AW-1:0]  ex_rd, mem_rd, wb_rd;
  logic [DW-1:0]  ex_out, mem_out, mem_read_data, mem_pc_next, wb_data;
  logic [1:0]     mem_memtoreg;
  logic [NS*2-1:0] fwd_sel;
`ifdef FWD_PERF_CNT_EN
  logic [31:0]    perf_lu_cnt, perf_fwd_cnt;
`endif
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] a0, a1, rf0, rf1;
    logic [31:0] ex_rw, ex_mr, ex_rd, ex_out;
    logic [31:0] mem_rw, mem_rd, mem_mtr, mem_out, mem_rdd, mem_pc;
    logic [31:0] wb_rw, wb_rd, wb_data;
    logic [31:0] e_op0, e_op1, e_sel0, e_sel1, e_lu;
  } vec_t;
  vec_t v[8];

  operand_forward_unit #(.DATA_W(DW), .REG_AW(AW), .NUM_SRC(NS)) dut (
    .clk(clk), .rst_n(rst_n), .id_hold(id_hold), .src_addr(src_addr), .src_rf_data(src_rf_data),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_out(ex_out),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_memtoreg(mem_memtoreg), .mem_out(mem_out),
    .mem_read_data(mem_read_data), .mem_pc_next(mem_pc_next),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .op_out(op_out), .fwd_sel(fwd_sel), .lu_stall(lu_stall)
`ifdef FWD_PERF_CNT_EN
    , .perf_lu_cnt(perf_lu_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    src_addr = '0; src_rf_data = '0;
    ex_regwrite = 0; ex_memread = 0; ex_rd = '0; ex_out = '0;
    mem_regwrite = 0; mem_rd = '0; mem_memtoreg = 2'b00; mem_out = '0; mem_read_data = '0; mem_pc_next = '0;
    wb_regwrite = 0; wb_rd = '0; wb_data = '0;
  endtask

  task automatic apply(input vec_t t);
    src_addr = {t.a1[AW-1:0], t.a0[AW-1:0]};
    src_rf_data = {t.rf1, t.rf0};
    ex_regwrite = t.ex_rw[0]; ex_memread = t.ex_mr[0]; ex_rd = t.ex_rd[AW-1:0]; ex_out = t.ex_out;
    mem_regwrite = t.mem_rw[0]; mem_rd = t.mem_rd[AW-1:0]; mem_memtoreg = t.mem_mtr[1:0];
    mem_out = t.mem_out; mem_read_data = t.mem_rdd; mem_pc_next = t.mem_pc;
    wb_regwrite = t.wb_rw[0]; wb_rd = t.wb_rd[AW-1:0]; wb_data = t.wb_data;
  endtask

  initial begin
    v[0] = '{3, 4, 'hA0, 'hA1, 1, 0, 3, 'h11, 1, 3, 0, 'h22, 0, 0, 1, 4, 'h44, 'h11, 'h44, 1, 3, 0};
    v[1] = '{0, 0, 'hB0, 'hB1, 1, 1, 0, 'hFFFF, 1, 0, 0, 'hFFFF, 'hFFFF, 'hFFFF, 1, 0, 'hFFFF, 'hB0, 'hB1, 0, 0, 0};
    v[2] = '{2, 31, 'hC0, 'hC1, 1, 0, 9, 'h9, 1, 31, 2, 'h5, 'h6, 'h400010, 1, 2, 'h222, 'h222, 'h400010, 3, 2, 0};
    v[3] = '{5, 31, 'hD0, 'hD1, 0, 0, 0, 0, 1, 31, 3, 'h5, 'h6, 'h1234, 0, 0, 0, 'hD0, 'h1234, 0, 2, 0};
    v[4] = '{6, 6, 'hE0, 'hE1, 0, 0, 0, 0, 1, 6, 0, 'h66, 'h67, 'h68, 1, 6, 'h99, 'h66, 'h66, 2, 2, 0};
    v[5] = '{8, 5, 'hF0, 'hF1, 1, 1, 5, 'hDEAD, 1, 5, 1, 'h55, 'hBEEF, 'h57, 1, 8, 'h88, 'h88, 'hBEEF, 3, 2, 1};
    v[6] = '{5, 7, 'h10, 'h11, 1, 1, 5, 'hDEAD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h10, 'h11, 0, 0, 1};
    v[7] = '{3, 3, 'h20, 'h21, 0, 0, 3, 'h11, 0, 3, 0, 'h22, 0, 0, 0, 3, 'h33, 'h20, 'h21, 0, 0, 0};

    idle();
    src_addr = {5'd3, 5'd3}; src_rf_data = {32'h5B, 32'h5A};
    ex_regwrite = 1; ex_rd = 5'd3; ex_out = 32'h99;
    #3;
    chk("rst_state", 32'(dut.state), 32'(RUN));
    chk("rst_op0", op_out[31:0], 32'h99);
    chk("rst_op1", op_out[63:32], 32'h99);
    ex_regwrite = 0;
    #1;
    chk("rst_rf_op0", op_out[31:0], 32'h5A);
`ifdef FWD_PERF_CNT_EN
    chk("rst_perf_lu", perf_lu_cnt, 0);
    chk("rst_perf_fwd", perf_fwd_cnt, 0);
`endif
    @(posedge clk); #1;
    rst_n = 1;

    for (int i = 0; i < 8; i++) begin
      apply(v[i]);
      #2;
      chk($sformatf("v%0d_op0", i), op_out[31:0], v[i].e_op0);
      chk($sformatf("v%0d_op1", i), op_out[63:32], v[i].e_op1);
      chk($sformatf("v%0d_sel0", i), 32'(fwd_sel[1:0]), v[i].e_sel0);
      chk($sformatf("v%0d_sel1", i), 32'(fwd_sel[3:2]), v[i].e_sel1);
      chk($sformatf("v%0d_lu", i), 32'(lu_stall), v[i].e_lu);
      @(posedge clk); #1;
    end
    idle();
    @(posedge clk); #1;
    chk("idle_state", 32'(dut.state), 32'(RUN));

    // load-use: one stall cycle, then the load supplies data from MEM
    src_addr = {5'd5, 5'd0}; src_rf_data = {32'h1, 32'h0};
    ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd5; ex_out = 32'h1111;
    #2;
    chk("lu_stall_hi", 32'(lu_stall), 1);
    chk("lu_op1_rf", op_out[63:32], 32'h1);
    @(posedge clk); #1;
    chk("lu_state", 32'(dut.state), 32'(LU));
    ex_regwrite = 0; ex_memread = 0;
    mem_regwrite = 1; mem_rd = 5'd5; mem_memtoreg = MTR_MEM; mem_read_data = 32'hCAFE; mem_out = 32'h5;
    #2;
    chk("lu_stall_lo", 32'(lu_stall), 0);
    chk("lu_op1_cafe", op_out[63:32], 32'hCAFE);
    chk("lu_sel1", 32'(fwd_sel[3:2]), 2);
    @(posedge clk); #1;
    chk("lu_back_run", 32'(dut.state), 32'(RUN));

    // freeze: WB value retires mid-hold and must persist
    idle();
    src_addr = {5'd0, 5'd7}; src_rf_data = '0;
    id_hold = 1;
    #2;
    chk("h1_op0", op_out[31:0], 0);
    chk("h1_sel0", 32'(fwd_sel[1:0]), 0);
    @(posedge clk); #1;
    chk("h_state", 32'(dut.state), 32'(HOLD));
    wb_regwrite = 1; wb_rd = 5'd7; wb_data = 32'h77;
    #2;
    chk("h2_op0", op_out[31:0], 32'h77);
    chk("h2_sel0", 32'(fwd_sel[1:0]), 3);
    @(posedge clk); #1;
    wb_regwrite = 0; wb_data = '0;
    #2;
    chk("h3_op0", op_out[31:0], 32'h77);
    chk("h3_sel0", 32'(fwd_sel[1:0]), 0);
    @(posedge clk); #1;
    ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd7; ex_out = 32'hEE;
    #2;
    chk("h4_lu_masked", 32'(lu_stall), 0);
    chk("h4_op0", op_out[31:0], 32'h77);
    @(posedge clk); #1;
    ex_regwrite = 0; ex_memread = 0; id_hold = 0;
    #2;
    chk("hdrop_op0", op_out[31:0], 32'h77);
    @(posedge clk); #1;
    chk("hafter_op0_rf", op_out[31:0], 0);
    chk("hafter_state", 32'(dut.state), 32'(RUN));

    // reset in the middle of a hold discards the latched value
    idle();
    src_addr = {5'd0, 5'd7}; src_rf_data = {32'h0, 32'h12};
    id_hold = 1; wb_regwrite = 1; wb_rd = 5'd7; wb_data = 32'h55;
    @(posedge clk); #1;
    wb_regwrite = 0; wb_data = '0;
    #2;
    chk("rh_op0_held", op_out[31:0], 32'h55);
    rst_n = 0;
    #1;
    chk("rh_op0_rf", op_out[31:0], 32'h12);
    chk("rh_state", 32'(dut.state), 32'(RUN));
`ifdef FWD_PERF_CNT_EN
    chk("rh_perf_lu", perf_lu_cnt, 0);
    chk("rh_perf_fwd", perf_fwd_cnt, 0);
`endif
    @(posedge clk); #1;
    id_hold = 0; rst_n = 1;
    @(posedge clk); #1;
    chk("final_op0", op_out[31:0], 32'h12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
